conv_mac_sequencer: RTL and testbench

- Sequences one 3x3 convolution window through the shared matrixAccelerator multiply/accumulate datapath.
- Accepts a full window plus filter coefficients and issues ceil(KERNEL_ELEMS/LANES) multiply passes over LANES multiplier lanes.
- Pulses lane adds after each pass, then the final add, and returns the accumulated sum on a valid/ready result port.
- Sits between Convolution_Controller's window/filter registers and the accelerator, replacing ad-hoc mStart/Add/finalAdd driving.

---
 rtl/conv_mac_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_conv_mac_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_sequencer.sv
// rtl/conv_mac_sequencer.sv - sequences one convolution window through the shared multiply/accumulate datapath
module conv_mac_sequencer #(
  parameter int KERNEL_ELEMS = 9,
  parameter int LANES        = 3,
  parameter int BIT_LEN      = 16,
  parameter int ACC_W        = 32,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            win_valid,
  output logic                            win_ready,
  input  logic [KERNEL_ELEMS*BIT_LEN-1:0] win_data,
  input  logic [KERNEL_ELEMS*BIT_LEN-1:0] filt_data,
  output logic [LANES*BIT_LEN-1:0]        mul_a,
  output logic [LANES*BIT_LEN-1:0]        mul_b,
  output logic [LANES-1:0]                m_start,
  input  logic [LANES-1:0]                m_ready,
  output logic [LANES-1:0]                acc_add,
  output logic                            final_add,
  output logic                            acc_clr,
  input  logic [ACC_W-1:0]                final_sum,
  input  logic                            final_ready,
  output logic                            res_valid,
  output logic [ACC_W-1:0]                res_data,
  input  logic                            res_ready,
  output logic                            busy,
  output logic                            err_timeout
);

  localparam int PASSES = (KERNEL_ELEMS + LANES - 1) / LANES;
  localparam int PASS_W = $clog2(PASSES + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int WIN_W  = KERNEL_ELEMS * BIT_LEN;
  localparam int OP_W   = LANES * BIT_LEN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT_MUL,
    S_ACCUM,
    S_FINAL,
    S_WAIT_FIN,
    S_OUT
  } state_t;

  state_t             state_q, state_d;
  logic [PASS_W-1:0]  pass_q, pass_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [WIN_W-1:0]   filt_q, filt_d;
  logic [OP_W-1:0]    mul_a_q, mul_a_d;
  logic [OP_W-1:0]    mul_b_q, mul_b_d;
  logic [ACC_W-1:0]   res_data_q, res_data_d;
  logic               err_q, err_d;
  logic               load_ops;
  logic               wd_expire;

  // Next-state, pulse outputs and datapath register updates for the pass sequencer.
  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    wd_d       = '0;
    win_d      = win_q;
    filt_d     = filt_q;
    res_data_d = res_data_q;
    err_d      = err_q;
    load_ops   = 1'b0;
    wd_expire  = (wd_q == WD_W'(TIMEOUT_CYC - 1));
    win_ready  = 1'b0;
    m_start    = '0;
    acc_add    = '0;
    final_add  = 1'b0;
    acc_clr    = 1'b0;
    res_valid  = 1'b0;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        win_ready = 1'b1;
        if (win_valid) begin
          win_d   = win_data;
          filt_d  = filt_data;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        acc_clr  = 1'b1;
        pass_d   = '0;
        load_ops = 1'b1;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        m_start = '1;
        state_d = S_WAIT_MUL;
      end
      S_WAIT_MUL: begin
        // A completing multiply takes priority over a watchdog expiring on the same cycle.
        if (&m_ready) begin
          state_d = S_ACCUM;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          acc_clr = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_ACCUM: begin
        acc_add = '1;
        pass_d  = pass_q + 1'b1;
        if (pass_q == PASS_W'(PASSES - 1)) begin
          state_d = S_FINAL;
        end else begin
          load_ops = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_FINAL: begin
        final_add = 1'b1;
        state_d   = S_WAIT_FIN;
      end
      S_WAIT_FIN: begin
        if (final_ready) begin
          res_data_d = final_sum;
          state_d    = S_OUT;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          acc_clr = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand steering: lane l of the upcoming pass carries element pass*LANES+l, zero past the window end.
  always_comb begin
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    if (load_ops) begin
      for (int l = 0; l < LANES; l++) begin
        mul_a_d[l*BIT_LEN +: BIT_LEN] = '0;
        mul_b_d[l*BIT_LEN +: BIT_LEN] = '0;
        for (int k = 0; k < KERNEL_ELEMS; k++) begin
          if ((int'(pass_d) * LANES + l) == k) begin
            mul_a_d[l*BIT_LEN +: BIT_LEN] = win_q[k*BIT_LEN +: BIT_LEN];
            mul_b_d[l*BIT_LEN +: BIT_LEN] = filt_q[k*BIT_LEN +: BIT_LEN];
          end
        end
      end
    end
  end

  // State and datapath registers; reset abandons any window in flight.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      pass_q     <= '0;
      wd_q       <= '0;
      win_q      <= '0;
      filt_q     <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      wd_q       <= wd_d;
      win_q      <= win_d;
      filt_q     <= filt_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
    end
  end

  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign res_data    = res_data_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// tb/tb_conv_mac_sequencer.sv - self-checking bench for conv_mac_sequencer with a behavioural accelerator
module tb_conv_mac_sequencer;

  localparam int KE     = 9;
  localparam int LANES  = 3;
  localparam int BL     = 16;
  localparam int AW     = 32;
  localparam int TO     = 255;
  localparam int PASSES = (KE + LANES - 1) / LANES;
  localparam int MIN_LAT = 1 + PASSES * 3 + 1 + 1;

  typedef logic [BL-1:0] vec_t [KE];

  logic               Clk = 1'b0;
  logic               Rst = 1'b1;
  logic               win_valid = 1'b0;
  logic               win_ready;
  logic [KE*BL-1:0]   win_data = '0;
  logic [KE*BL-1:0]   filt_data = '0;
  logic [LANES*BL-1:0] mul_a, mul_b;
  logic [LANES-1:0]   m_start;
  logic [LANES-1:0]   m_ready = '0;
  logic [LANES-1:0]   acc_add;
  logic               final_add, acc_clr;
  logic [AW-1:0]      final_sum = '0;
  logic               final_ready = 1'b0;
  logic               res_valid;
  logic [AW-1:0]      res_data;
  logic               res_ready = 1'b0;
  logic               busy, err_timeout;

  int passed = 0;
  int total  = 0;

  // accelerator model state
  int             mul_lat = 1;
  int             fin_lat = 1;
  logic [LANES-1:0] hold_mask = '0;
  int             mul_tmr = 0;
  int             fin_tmr = 0;
  bit             mr_int = 1'b0;
  logic [AW-1:0]  acc = '0;
  logic [AW-1:0]  prod [LANES];
  logic [BL-1:0]  pa [PASSES][LANES];
  logic [BL-1:0]  pb [PASSES][LANES];
  int             ps_idx = 0;
  logic [LANES*BL-1:0] cap_a = '0, cap_b = '0;
  bit             in_pass = 1'b0;
  bit             op_unstable = 1'b0;
  int             n_start = 0, n_add = 0, n_final = 0, n_clr = 0, bad_pulse = 0;

  conv_mac_sequencer #(
    .KERNEL_ELEMS(KE), .LANES(LANES), .BIT_LEN(BL), .ACC_W(AW), .TIMEOUT_CYC(TO)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .filt_data(filt_data),
    .mul_a(mul_a), .mul_b(mul_b),
    .m_start(m_start), .m_ready(m_ready),
    .acc_add(acc_add), .final_add(final_add), .acc_clr(acc_clr),
    .final_sum(final_sum), .final_ready(final_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 500us");
    $fatal(1);
  end

  // Accelerator: multiplies on start, accumulates on add, presents the total after final add.
  always @(negedge Clk) begin
    if (Rst) begin
      mr_int = 1'b0; mul_tmr = 0; fin_tmr = 0; final_ready = 1'b0;
      acc = '0; in_pass = 1'b0; ps_idx = 0;
    end else begin
      if (acc_clr) begin
        n_clr++; acc = '0; ps_idx = 0;
      end
      if (m_start != '0) begin
        if (m_start == '1) n_start++; else bad_pulse++;
        for (int l = 0; l < LANES; l++) begin
          prod[l] = AW'(mul_a[l*BL +: BL]) * AW'(mul_b[l*BL +: BL]);
          if (ps_idx < PASSES) begin
            pa[ps_idx][l] = mul_a[l*BL +: BL];
            pb[ps_idx][l] = mul_b[l*BL +: BL];
          end
        end
        ps_idx++;
        cap_a = mul_a; cap_b = mul_b; in_pass = 1'b1;
        mul_tmr = mul_lat - 1; mr_int = (mul_tmr == 0);
        final_ready = 1'b0;
      end else begin
        if (in_pass && (mul_a !== cap_a || mul_b !== cap_b)) op_unstable = 1'b1;
        if (mul_tmr > 0) begin
          mul_tmr--; mr_int = (mul_tmr == 0);
        end
      end
      if (acc_add != '0) begin
        if (acc_add == '1) n_add++; else bad_pulse++;
        for (int l = 0; l < LANES; l++) acc = acc + prod[l];
        in_pass = 1'b0;
      end
      if (final_add) begin
        n_final++; final_sum = acc; fin_tmr = fin_lat - 1; final_ready = (fin_tmr == 0);
      end else if (fin_tmr > 0) begin
        fin_tmr--; final_ready = (fin_tmr == 0);
      end
    end
    m_ready = {LANES{mr_int}} & ~hold_mask;
  end

  function automatic logic [KE*BL-1:0] pack(input vec_t v);
    logic [KE*BL-1:0] p;
    p = '0;
    for (int k = 0; k < KE; k++) p[k*BL +: BL] = v[k];
    return p;
  endfunction

  // Reference: dot product of window and filter, wrapped to the result width.
  function automatic logic [AW-1:0] ref_conv(input vec_t w, input vec_t f);
    longint s;
    s = 0;
    for (int k = 0; k < KE; k++) s = s + longint'(w[k]) * longint'(f[k]);
    return AW'(s);
  endfunction

  task automatic clear_counts();
    n_start = 0; n_add = 0; n_final = 0; n_clr = 0; bad_pulse = 0; op_unstable = 1'b0;
  endtask

  task automatic do_window(input vec_t w, input vec_t f, output logic [AW-1:0] res,
                           output int lat, output bit got);
    int n;
    @(negedge Clk);
    win_data = pack(w); filt_data = pack(f); win_valid = 1'b1;
    n = 0;
    while (!win_ready && n < 100) begin
      @(negedge Clk); n++;
    end
    got = 1'b0; lat = 0; res = '0;
    if (win_ready) begin
      @(posedge Clk); #1;
      win_valid = 1'b0;
      while (!res_valid && lat < 2000) begin
        @(posedge Clk); #1; lat++;
      end
      got = res_valid; res = res_data;
    end else begin
      win_valid = 1'b0;
    end
  endtask

  task automatic ack_result(input int delay);
    for (int i = 0; i < delay; i++) begin
      @(posedge Clk); #1;
    end
    res_ready = 1'b1;
    @(posedge Clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; win_valid = 1'b0; res_ready = 1'b0; hold_mask = '0;
    repeat (3) @(posedge Clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else passed++;
    total++; if (err_timeout !== 1'b0) $display("FAIL reset_err: got %b want 0", err_timeout); else passed++;
    total++; if ({m_start, acc_add, final_add, acc_clr} !== '0)
      $display("FAIL reset_pulses: got %b want 0", {m_start, acc_add, final_add, acc_clr}); else passed++;
    total++; if ({mul_a, mul_b} !== '0) $display("FAIL reset_operands: got %h want 0", {mul_a, mul_b}); else passed++;
    total++; if (res_data !== '0) $display("FAIL reset_res_data: got %h want 0", res_data); else passed++;
    @(negedge Clk); Rst = 1'b0; #1;
    total++; if (win_ready !== 1'b1) $display("FAIL reset_win_ready: got %b want 1", win_ready); else passed++;
  endtask

  task automatic test_basic();
    vec_t w, f; logic [AW-1:0] r; int lat; bit got;
    for (int k = 0; k < KE; k++) begin w[k] = BL'(1); f[k] = BL'(k); end
    clear_counts();
    do_window(w, f, r, lat, got);
    total++; if (got !== 1'b1) $display("FAIL basic_result_seen: got %b want 1", got); else passed++;
    total++; if (r !== ref_conv(w, f)) $display("FAIL basic_sum: got %0d want %0d", r, ref_conv(w, f)); else passed++;
    total++; if (lat != MIN_LAT) $display("FAIL basic_latency: got %0d want %0d", lat, MIN_LAT); else passed++;
    ack_result(0);
    total++; if (n_start != PASSES) $display("FAIL basic_m_start_count: got %0d want %0d", n_start, PASSES); else passed++;
    total++; if (n_add != PASSES) $display("FAIL basic_acc_add_count: got %0d want %0d", n_add, PASSES); else passed++;
    total++; if (n_final != 1) $display("FAIL basic_final_add_count: got %0d want 1", n_final); else passed++;
    total++; if (n_clr != 1) $display("FAIL basic_acc_clr_count: got %0d want 1", n_clr); else passed++;
    total++; if (bad_pulse != 0) $display("FAIL basic_partial_pulses: got %0d want 0", bad_pulse); else passed++;
    total++; if (op_unstable !== 1'b0) $display("FAIL basic_operand_stability: got %b want 0", op_unstable); else passed++;
  endtask

  task automatic test_operands();
    vec_t w, f; logic [AW-1:0] r; int lat; bit got;
    for (int k = 0; k < KE; k++) begin w[k] = BL'(k + 1); f[k] = BL'(k); end
    clear_counts();
    do_window(w, f, r, lat, got);
    total++; if (r !== ref_conv(w, f) || got !== 1'b1)
      $display("FAIL operands_sum: got %0d (valid %b) want %0d", r, got, ref_conv(w, f)); else passed++;
    for (int l = 0; l < LANES; l++) begin
      total++; if (pa[1][l] !== BL'(4 + l))
        $display("FAIL pass1_mul_a_lane%0d: got %0d want %0d", l, pa[1][l], 4 + l); else passed++;
      total++; if (pb[1][l] !== BL'(3 + l))
        $display("FAIL pass1_mul_b_lane%0d: got %0d want %0d", l, pb[1][l], 3 + l); else passed++;
    end
    ack_result(0);
  endtask

  task automatic test_backpressure();
    vec_t w, f; logic [AW-1:0] r, exp_r; int lat; bit got;
    for (int k = 0; k < KE; k++) begin w[k] = BL'(k + 1); f[k] = BL'(k); end
    exp_r = ref_conv(w, f);
    do_window(w, f, r, lat, got);
    total++; if (got !== 1'b1) $display("FAIL bp_result_seen: got %b want 1", got); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      total++; if (res_valid !== 1'b1 || res_data !== exp_r || win_ready !== 1'b0)
        $display("FAIL bp_hold_cycle%0d: got valid=%b data=%0d win_ready=%b want 1/%0d/0",
                 i, res_valid, res_data, win_ready, exp_r); else passed++;
    end
    res_ready = 1'b1;
    @(posedge Clk); #1;
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b0 || busy !== 1'b0 || win_ready !== 1'b1)
      $display("FAIL bp_release: got valid=%b busy=%b win_ready=%b want 0/0/1", res_valid, busy, win_ready); else passed++;
  endtask

  task automatic test_timeout();
    vec_t w, f; logic [AW-1:0] r; int lat; bit got; int k; bit saw_res;
    for (int i = 0; i < KE; i++) begin w[i] = BL'(1); f[i] = BL'(i); end
    clear_counts();
    hold_mask = 3'b010;
    @(negedge Clk);
    win_data = pack(w); filt_data = pack(f); win_valid = 1'b1;
    @(posedge Clk); #1;
    win_valid = 1'b0;
    k = 0; saw_res = 1'b0;
    while (!err_timeout && k < 400) begin
      @(posedge Clk); #1; k++;
      if (res_valid) saw_res = 1'b1;
    end
    total++; if (err_timeout !== 1'b1) $display("FAIL timeout_err_set: got %b want 1", err_timeout); else passed++;
    total++; if (k != 2 + TO) $display("FAIL timeout_cycle: got %0d want %0d", k, 2 + TO); else passed++;
    total++; if (win_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL timeout_idle: got win_ready=%b busy=%b want 1/0", win_ready, busy); else passed++;
    total++; if (saw_res !== 1'b0) $display("FAIL timeout_no_result: got %b want 0", saw_res); else passed++;
    total++; if (n_clr != 2) $display("FAIL timeout_acc_clr_count: got %0d want 2", n_clr); else passed++;
    hold_mask = '0;
    do_window(w, f, r, lat, got);
    total++; if (r !== ref_conv(w, f) || got !== 1'b1)
      $display("FAIL timeout_recover_sum: got %0d (valid %b) want %0d", r, got, ref_conv(w, f)); else passed++;
    ack_result(1);
    total++; if (err_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", err_timeout); else passed++;
  endtask

  task automatic test_reset_mid();
    vec_t w, f; logic [AW-1:0] r; int lat; bit got; int k;
    for (int i = 0; i < KE; i++) begin w[i] = BL'(i + 1); f[i] = BL'(i); end
    clear_counts();
    mul_lat = 6;
    @(negedge Clk);
    win_data = pack(w); filt_data = pack(f); win_valid = 1'b1;
    @(posedge Clk); #1;
    win_valid = 1'b0;
    k = 0;
    while (n_start < 2 && k < 100) begin
      @(negedge Clk); #1; k++;
    end
    @(posedge Clk); #2;
    total++; if (busy !== 1'b1 || n_start != 2)
      $display("FAIL midrst_precondition: got busy=%b starts=%0d want 1/2", busy, n_start); else passed++;
    Rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || res_valid !== 1'b0 || err_timeout !== 1'b0)
      $display("FAIL midrst_status: got busy=%b valid=%b err=%b want 0/0/0", busy, res_valid, err_timeout); else passed++;
    total++; if ({m_start, acc_add, final_add, acc_clr} !== '0 || {mul_a, mul_b} !== '0)
      $display("FAIL midrst_outputs: got pulses=%b ops=%h want 0", {m_start, acc_add, final_add, acc_clr}, {mul_a, mul_b}); else passed++;
    @(negedge Clk); Rst = 1'b0;
    mul_lat = 1;
    do_window(w, f, r, lat, got);
    total++; if (r !== ref_conv(w, f) || got !== 1'b1)
      $display("FAIL midrst_recover_sum: got %0d (valid %b) want %0d", r, got, ref_conv(w, f)); else passed++;
    ack_result(0);
  endtask

  task automatic test_back_to_back();
    vec_t w1, f1, w2, f2; int k; bit early;
    for (int i = 0; i < KE; i++) begin
      w1[i] = BL'($urandom); f1[i] = BL'($urandom);
      w2[i] = BL'($urandom); f2[i] = BL'($urandom);
    end
    @(negedge Clk);
    win_data = pack(w1); filt_data = pack(f1); win_valid = 1'b1;
    @(posedge Clk); #1;
    win_data = pack(w2); filt_data = pack(f2);
    k = 0; early = 1'b0;
    while (!res_valid && k < 2000) begin
      if (win_ready) early = 1'b1;
      @(posedge Clk); #1; k++;
    end
    total++; if (res_valid !== 1'b1 || res_data !== ref_conv(w1, f1))
      $display("FAIL b2b_first_sum: got %0d (valid %b) want %0d", res_data, res_valid, ref_conv(w1, f1)); else passed++;
    total++; if (early !== 1'b0) $display("FAIL b2b_early_ready: got %b want 0", early); else passed++;
    repeat (2) @(posedge Clk);
    #1;
    total++; if (win_ready !== 1'b0 || res_valid !== 1'b1)
      $display("FAIL b2b_hold: got win_ready=%b valid=%b want 0/1", win_ready, res_valid); else passed++;
    res_ready = 1'b1;
    @(posedge Clk); #1;
    res_ready = 1'b0;
    total++; if (busy !== 1'b0 || win_ready !== 1'b1 || res_valid !== 1'b0)
      $display("FAIL b2b_handshake_idle: got busy=%b win_ready=%b valid=%b want 0/1/0", busy, win_ready, res_valid); else passed++;
    @(posedge Clk); #1;
    win_valid = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_second_accept: got busy=%b want 1", busy); else passed++;
    k = 0;
    while (!res_valid && k < 2000) begin
      @(posedge Clk); #1; k++;
    end
    total++; if (res_valid !== 1'b1 || res_data !== ref_conv(w2, f2))
      $display("FAIL b2b_second_sum: got %0d (valid %b) want %0d", res_data, res_valid, ref_conv(w2, f2)); else passed++;
    ack_result(0);
  endtask

  task automatic test_random();
    vec_t w, f; logic [AW-1:0] r; int lat; bit got;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < KE; i++) begin w[i] = BL'($urandom); f[i] = BL'($urandom); end
      mul_lat = int'($urandom_range(1, 4));
      fin_lat = int'($urandom_range(1, 3));
      clear_counts();
      do_window(w, f, r, lat, got);
      total++; if (r !== ref_conv(w, f) || got !== 1'b1)
        $display("FAIL random%0d_sum: got %0d (valid %b) want %0d", it, r, got, ref_conv(w, f)); else passed++;
      total++; if (op_unstable !== 1'b0 || n_start != PASSES)
        $display("FAIL random%0d_passes: got unstable=%b starts=%0d want 0/%0d", it, op_unstable, n_start, PASSES); else passed++;
      ack_result(int'($urandom_range(0, 3)));
    end
    mul_lat = 1;
    fin_lat = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_operands();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
